// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit flag positions, port order and LFSR taps.
package minbd_pkg;

  localparam int FLIT_W_DEF     = 11;
  localparam int VLD_BIT_DEF    = 10;
  localparam int GOLD_BIT_DEF   = 9;
  localparam int SILVER_BIT_DEF = 8;

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_S = 2'd1,
    PORT_E = 2'd2,
    PORT_W = 2'd3
  } port_e;

  // x^8 + x^6 + x^5 + x^4 + 1 mapped onto state bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rr_first_find.sv
// Combinational cyclic priority finder: first set bit of elig scanning from start upward, wrapping.
module rr_first_find #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] winner,
  output logic          found
);

  // Scan downward so the nearest index to start is the last one written.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[(int'(start) + k) % N]) begin
        winner = IW'((int'(start) + k) % N);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/silver_flit_sel.sv
// Registered silver-flit selector: nominates one valid non-golden flit per cycle, 1-cycle latency.
// No backpressure; en=0 freezes every register and ignores flit_in.
module silver_flit_sel
  import minbd_pkg::*;
#(
  parameter int         PORTS      = 4,
  parameter int         FLIT_W     = FLIT_W_DEF,
  parameter int         VLD_BIT    = VLD_BIT_DEF,
  parameter int         GOLD_BIT   = GOLD_BIT_DEF,
  parameter int         SILVER_BIT = SILVER_BIT_DEF,
  parameter int         MODE       = 0,
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  localparam int        IW         = (PORTS > 2) ? $clog2(PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [PORTS*FLIT_W-1:0] flit_in,
  output logic [PORTS*FLIT_W-1:0] flit_out,
  output logic                    silver_vld,
  output logic [IW-1:0]           silver_idx,
  output logic [15:0]             sel_cnt
);

  logic [PORTS-1:0]        w_elig;
  logic [IW-1:0]           w_start;
  logic [IW-1:0]           w_winner;
  logic [IW-1:0]           w_ptr_nxt;
  logic                    w_found;
  logic [PORTS*FLIT_W-1:0] w_flit_nxt;

  logic [PORTS*FLIT_W-1:0] r_flit_out;
  logic                    r_silver_vld;
  logic [IW-1:0]           r_silver_idx;
  logic [IW-1:0]           r_ptr;
  logic [7:0]              r_lfsr;
  logic [15:0]             r_sel_cnt;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < PORTS; i++)
      w_elig[i] = flit_in[i*FLIT_W + VLD_BIT] & ~flit_in[i*FLIT_W + GOLD_BIT];
  end

  // Out-of-range LFSR start values fold to port 0 for non-power-of-two PORTS.
  always_comb begin
    w_start = r_ptr;
    if (MODE == 1) begin
      w_start = r_lfsr[IW-1:0];
      if (int'(r_lfsr[IW-1:0]) >= PORTS)
        w_start = '0;
    end
  end

  rr_first_find #(
    .N  (PORTS),
    .IW (IW)
  ) u_find (
    .elig   (w_elig),
    .start  (w_start),
    .winner (w_winner),
    .found  (w_found)
  );

  // Incoming silver flags are per-router and always rewritten here.
  always_comb begin
    w_flit_nxt = flit_in;
    for (int i = 0; i < PORTS; i++)
      w_flit_nxt[i*FLIT_W + SILVER_BIT] = w_found && (w_winner == IW'(i));
  end

  assign w_ptr_nxt = (int'(w_winner) == PORTS - 1) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_out   <= '0;
      r_silver_vld <= 1'b0;
      r_silver_idx <= '0;
      r_ptr        <= '0;
      r_lfsr       <= LFSR_SEED;
      r_sel_cnt    <= '0;
    end else if (en) begin
      r_flit_out   <= w_flit_nxt;
      r_silver_vld <= w_found;
      r_silver_idx <= w_winner;
      if (MODE == 0 && w_found)
        r_ptr <= w_ptr_nxt;
      if (MODE == 1)
        r_lfsr <= lfsr_next(r_lfsr);
      if (w_found && r_sel_cnt != 16'hFFFF)
        r_sel_cnt <= r_sel_cnt + 16'd1;
    end
  end

  assign flit_out   = r_flit_out;
  assign silver_vld = r_silver_vld;
  assign silver_idx = r_silver_idx;
  assign sel_cnt    = r_sel_cnt;

endmodule

// File: tb/tb_silver_flit_sel.sv
// Bench for silver_flit_sel: round-robin and LFSR instances share stimulus, scoreboard queues hold expectations.
module tb_silver_flit_sel;

  typedef struct {
    logic [43:0] flits;
    logic        vld;
    logic [1:0]  idx;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [43:0] flit_in = '0;

  logic [43:0] rr_flit_out, lf_flit_out;
  logic        rr_vld, lf_vld;
  logic [1:0]  rr_idx, lf_idx;
  logic [15:0] rr_cnt, lf_cnt;

  int errors = 0;
  int checks = 0;

  exp_t q_rr[$];
  exp_t q_lf[$];
  exp_t e_rr, e_lf;

  int          m_ptr = 0;
  logic [7:0]  m_lfsr = 8'hA5;
  logic [15:0] m_cnt_rr = '0;
  logic [15:0] m_cnt_lf = '0;

  always #5 clk = ~clk;

  silver_flit_sel #(.PORTS(4), .MODE(0), .LFSR_SEED(8'hA5)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .flit_in(flit_in),
    .flit_out(rr_flit_out), .silver_vld(rr_vld), .silver_idx(rr_idx), .sel_cnt(rr_cnt)
  );

  silver_flit_sel #(.PORTS(4), .MODE(1), .LFSR_SEED(8'hA5)) u_lf (
    .clk(clk), .rst_n(rst_n), .en(en), .flit_in(flit_in),
    .flit_out(lf_flit_out), .silver_vld(lf_vld), .silver_idx(lf_idx), .sel_cnt(lf_cnt)
  );

  function automatic logic [43:0] pack(input logic [10:0] n, input logic [10:0] s,
                                       input logic [10:0] e, input logic [10:0] w);
    return {w, e, s, n};
  endfunction

  // Reference selection: scan start, start+1, ... for valid & !golden.
  function automatic exp_t model(input logic [43:0] f, input int start, input logic [15:0] cnt);
    exp_t r;
    int   w;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int p;
      p = (start + k) % 4;
      if (w < 0 && f[p*11 + 10] && !f[p*11 + 9])
        w = p;
    end
    r.flits = f;
    for (int p = 0; p < 4; p++)
      r.flits[p*11 + 8] = (p == w);
    r.vld = (w >= 0);
    r.idx = r.vld ? 2'(w) : 2'd0;
    r.cnt = (r.vld && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    return r;
  endfunction

  task automatic drive(input logic [43:0] f);
    exp_t e;
    flit_in = f;
    en = 1'b1;
    e = model(f, m_ptr, m_cnt_rr);
    q_rr.push_back(e);
    m_cnt_rr = e.cnt;
    if (e.vld) m_ptr = (int'(e.idx) + 1) % 4;
    e = model(f, int'(m_lfsr[1:0]), m_cnt_lf);
    q_lf.push_back(e);
    m_cnt_lf = e.cnt;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    @(posedge clk);
    #1;
    e_rr = q_rr.pop_front();
    e_lf = q_lf.pop_front();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    q_rr.delete();
    q_lf.delete();
    m_ptr = 0;
    m_lfsr = 8'hA5;
    m_cnt_rr = '0;
    m_cnt_lf = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rr_flit_out !== 44'd0 || rr_vld !== 1'b0 || rr_idx !== 2'd0 || rr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_rr got flits=%h vld=%b idx=%0d cnt=%0d want all 0", rr_flit_out, rr_vld, rr_idx, rr_cnt);
    end
    checks++;
    if (lf_flit_out !== 44'd0 || lf_vld !== 1'b0 || lf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_lf got flits=%h vld=%b cnt=%0d want all 0", lf_flit_out, lf_vld, lf_cnt);
    end
    do_reset();
  endtask

  task automatic test_rotation();
    logic [43:0] f;
    f = pack(11'h404, 11'h405, 11'h406, 11'h407);
    for (int c = 0; c < 5; c++) begin
      drive(f);
      checks++;
      if (rr_flit_out !== e_rr.flits || rr_vld !== 1'b1 || rr_idx !== 2'(c % 4)) begin
        errors++;
        $display("FAIL rotation[%0d] got flits=%h vld=%b idx=%0d want flits=%h vld=1 idx=%0d",
                 c, rr_flit_out, rr_vld, rr_idx, e_rr.flits, c % 4);
      end
      if (c == 0) begin
        checks++;
        if (rr_flit_out !== pack(11'h504, 11'h405, 11'h406, 11'h407)) begin
          errors++;
          $display("FAIL rotation_first got %h want %h", rr_flit_out, pack(11'h504, 11'h405, 11'h406, 11'h407));
        end
      end
    end
    checks++;
    if (rr_cnt !== 16'd5) begin
      errors++;
      $display("FAIL rotation_cnt got %0d want 5", rr_cnt);
    end
  endtask

  task automatic test_golden_wrap();
    // Only E eligible moves the pointer to 3.
    drive(pack(11'h000, 11'h000, 11'h406, 11'h000));
    checks++;
    if (rr_idx !== 2'd2 || rr_flit_out !== e_rr.flits) begin
      errors++;
      $display("FAIL setup_ptr3 got idx=%0d flits=%h want idx=2 flits=%h", rr_idx, rr_flit_out, e_rr.flits);
    end
    drive(pack(11'h000, 11'h405, 11'h000, 11'h607));
    checks++;
    if (rr_vld !== 1'b1 || rr_idx !== 2'd1 || rr_flit_out !== pack(11'h000, 11'h505, 11'h000, 11'h607)) begin
      errors++;
      $display("FAIL golden_wrap got vld=%b idx=%0d flits=%h want vld=1 idx=1 flits=%h",
               rr_vld, rr_idx, rr_flit_out, pack(11'h000, 11'h505, 11'h000, 11'h607));
    end
    checks++;
    if (lf_flit_out !== e_lf.flits || lf_idx !== e_lf.idx) begin
      errors++;
      $display("FAIL golden_lf got flits=%h idx=%0d want flits=%h idx=%0d", lf_flit_out, lf_idx, e_lf.flits, e_lf.idx);
    end
    drive(pack(11'h404, 11'h405, 11'h406, 11'h407));
    checks++;
    if (rr_idx !== 2'd2 || rr_cnt !== e_rr.cnt) begin
      errors++;
      $display("FAIL ptr_after_wrap got idx=%0d cnt=%0d want idx=2 cnt=%0d", rr_idx, rr_cnt, e_rr.cnt);
    end
  endtask

  task automatic test_no_cand();
    logic [15:0] cnt_before;
    cnt_before = rr_cnt;
    drive(pack(11'h000, 11'h104, 11'h704, 11'h600));
    checks++;
    if (rr_vld !== 1'b0 || rr_idx !== 2'd0 || rr_cnt !== cnt_before ||
        rr_flit_out !== pack(11'h000, 11'h004, 11'h604, 11'h600)) begin
      errors++;
      $display("FAIL no_cand got vld=%b idx=%0d cnt=%0d flits=%h want vld=0 idx=0 cnt=%0d flits=%h",
               rr_vld, rr_idx, rr_cnt, rr_flit_out, cnt_before, pack(11'h000, 11'h004, 11'h604, 11'h600));
    end
    checks++;
    if (lf_vld !== 1'b0 || lf_idx !== 2'd0) begin
      errors++;
      $display("FAIL no_cand_lf got vld=%b idx=%0d want 0 0", lf_vld, lf_idx);
    end
    // Incoming silver on an eligible flit is not trusted; pointer still at 3.
    drive(pack(11'h504, 11'h405, 11'h406, 11'h507));
    checks++;
    if (rr_idx !== 2'd3 || rr_flit_out !== pack(11'h404, 11'h405, 11'h406, 11'h507)) begin
      errors++;
      $display("FAIL ptr_held got idx=%0d flits=%h want idx=3 flits=%h",
               rr_idx, rr_flit_out, pack(11'h404, 11'h405, 11'h406, 11'h507));
    end
  endtask

  task automatic test_en_hold();
    drive(pack(11'h000, 11'h405, 11'h000, 11'h000));
    checks++;
    if (rr_idx !== 2'd1 || rr_flit_out !== e_rr.flits) begin
      errors++;
      $display("FAIL hold_setup got idx=%0d flits=%h want idx=1 flits=%h", rr_idx, rr_flit_out, e_rr.flits);
    end
    for (int c = 0; c < 3; c++) begin
      en = 1'b0;
      flit_in = {$urandom, $urandom_range(4095, 0)};
      @(posedge clk);
      #1;
      checks++;
      if (rr_flit_out !== e_rr.flits || rr_vld !== e_rr.vld || rr_idx !== e_rr.idx || rr_cnt !== e_rr.cnt) begin
        errors++;
        $display("FAIL en_hold_rr[%0d] got flits=%h vld=%b idx=%0d cnt=%0d want flits=%h vld=%b idx=%0d cnt=%0d",
                 c, rr_flit_out, rr_vld, rr_idx, rr_cnt, e_rr.flits, e_rr.vld, e_rr.idx, e_rr.cnt);
      end
      checks++;
      if (lf_flit_out !== e_lf.flits || lf_idx !== e_lf.idx || lf_cnt !== e_lf.cnt) begin
        errors++;
        $display("FAIL en_hold_lf[%0d] got idx=%0d cnt=%0d want idx=%0d cnt=%0d", c, lf_idx, lf_cnt, e_lf.idx, e_lf.cnt);
      end
    end
    drive(pack(11'h404, 11'h405, 11'h406, 11'h407));
    checks++;
    if (rr_idx !== 2'd2 || rr_cnt !== e_rr.cnt) begin
      errors++;
      $display("FAIL en_resume got idx=%0d cnt=%0d want idx=2 cnt=%0d", rr_idx, rr_cnt, e_rr.cnt);
    end
    checks++;
    if (lf_idx !== e_lf.idx || lf_cnt !== e_lf.cnt) begin
      errors++;
      $display("FAIL en_resume_lf got idx=%0d cnt=%0d want idx=%0d cnt=%0d", lf_idx, lf_cnt, e_lf.idx, e_lf.cnt);
    end
  endtask

  task automatic test_reset_mid();
    flit_in = pack(11'h404, 11'h405, 11'h406, 11'h407);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rr_flit_out !== 44'd0 || rr_vld !== 1'b0 || rr_idx !== 2'd0 || rr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid got flits=%h vld=%b idx=%0d cnt=%0d want all 0", rr_flit_out, rr_vld, rr_idx, rr_cnt);
    end
    do_reset();
    drive(pack(11'h404, 11'h405, 11'h406, 11'h407));
    checks++;
    if (rr_idx !== 2'd0 || rr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_resume_rr got idx=%0d cnt=%0d want idx=0 cnt=1", rr_idx, rr_cnt);
    end
    checks++;
    if (lf_idx !== 2'd1 || lf_cnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_resume_lf got idx=%0d cnt=%0d want idx=1 cnt=1", lf_idx, lf_cnt);
    end
  endtask

  task automatic test_lfsr();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      drive(pack(11'h404, 11'h405, 11'h406, 11'h407));
      checks++;
      if (lf_vld !== 1'b1 || lf_idx !== e_lf.idx || lf_flit_out !== e_lf.flits) begin
        errors++;
        $display("FAIL lfsr[%0d] got vld=%b idx=%0d flits=%h want vld=1 idx=%0d flits=%h",
                 c, lf_vld, lf_idx, lf_flit_out, e_lf.idx, e_lf.flits);
      end
    end
    checks++;
    if (lf_cnt !== 16'd20 || rr_cnt !== 16'd20) begin
      errors++;
      $display("FAIL lfsr_cnt got lf=%0d rr=%0d want 20", lf_cnt, rr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_golden_wrap();
    test_no_cand();
    test_en_hold();
    test_reset_mid();
    test_lfsr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/silver_flit_sel.md
# silver_flit_sel

Registered, parametrised silver-flit selector for the MinBD router pipeline. It replaces the combinational silver-flit stage. Each cycle it nominates at most one valid, non-golden incoming flit as the router's silver flit, using a rotating round-robin or LFSR pseudo-random start point. It then forwards all flits one cycle later with the silver flag rewritten. It sits between the input ejection/golden stage and the permutation network.

## Interface
- PORTS, 4, number of flit channels (N, S, E, W order for 4); 2..8
- FLIT_W, 11, flit width in bits
- VLD_BIT, 10, flit valid flag position
- GOLD_BIT, 9, golden flag position; golden flits are never silver
- SILVER_BIT, 8, silver flag position, rewritten by this block
- MODE, 0, 0 = round-robin start, 1 = LFSR start
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  pipeline advance; 0 = hold all state and outputs
- flit_in  in  PORTS*FLIT_W  input flits; port i at bits [i*FLIT_W +: FLIT_W]
- flit_out  out  PORTS*FLIT_W  registered flits with silver flag rewritten
- silver_vld  out  1  a silver flit was nominated in flit_out
- silver_idx  out  max(1,$clog2(PORTS))  port index of the silver flit; 0 when silver_vld=0
- sel_cnt  out  16  saturating count of nominations since reset

## Operation
- Eligibility: elig[i] = flit[VLD_BIT] & ~flit[GOLD_BIT].
- Start index:
  - MODE 0: start = ptr.
  - MODE 1: start = lfsr[$clog2(PORTS)-1:0]; if that value is ≥ PORTS, start = 0.
- Winner: the first eligible index scanning start, start+1, … modulo PORTS.
- Output flits: each flit_out[i] equals flit_in[i] with SILVER_BIT cleared. The winner instead has SILVER_BIT set.
- Invalid flits pass through unchanged except for the forced-clear silver flag.
- Incoming SILVER_BIT values are always discarded, because silver status is per-router.
- No eligible flit: silver_vld=0, silver_idx=0, all silver flags cleared.
- Pointer (MODE 0):
  - On a nomination, ptr <= (winner+1) mod PORTS.
  - With no nomination, ptr holds.
  - Wrap from PORTS-1 to 0 is required.
- LFSR (MODE 1): 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances once per en=1 cycle, whether or not a winner exists.
- sel_cnt increments on each en=1 cycle with a nomination and saturates at 16'hFFFF.

## Timing
- Latency: exactly 1 cycle. flit_in sampled at edge k appears on flit_out, silver_vld and silver_idx after edge k.
- en=0: flit_out, silver_vld, silver_idx, ptr, lfsr and sel_cnt all hold. flit_in is ignored.
- Reset values (asynchronous, immediate on rst_n falling):
  - flit_out=0, silver_vld=0, silver_idx=0, sel_cnt=0
  - ptr=0, lfsr=LFSR_SEED
- Reset mid-operation: in-flight flits are discarded, with no partial state.
- The first edge with rst_n=1 samples normally.
- No backpressure and no stall inputs; the block is bufferless-compatible.

## Structure
- The shared package `minbd_pkg` holds:
  - default flag bit positions (VLD/GOLD/SILVER)
  - FLIT_W default
  - the port index enum (N=0, S=1, E=2, W=3)
  - LFSR tap constant
- One sub-module: `rr_first_find`. It is a combinational cyclic priority finder: inputs elig and start, outputs winner index and found flag.
- The LFSR, pointer, counter and output registers live in the top module.

## Test plan
- **Round-robin rotation.** MODE 0, all valid non-golden: N=0x404, S=0x405, E=0x406, W=0x407, held 5 cycles.
  - Silver goes to ports 0, 1, 2, 3, 0 in turn (idx 0, 1, 2, 3, 0).
  - First output: N=0x504, others unchanged.
  - sel_cnt=5.
- **Golden exclusion and wrap.** ptr=3; W=0x607 (golden), N=0x000 (invalid), S=0x405.
  - Silver idx=1, S out=0x505.
  - W out=0x607 with silver cleared.
  - Next ptr=2.
- **No candidates.** All inputs 0x000 or golden.
  - silver_vld=0, idx=0.
  - ptr and sel_cnt unchanged.
  - An incoming silver bit (e.g. 0x504) emerges as 0x404.
- **Enable hold.** en=0 for 3 cycles while the inputs change.
  - Outputs, ptr and sel_cnt are frozen.
  - Selection resumes from the held ptr on en=1.
- **Reset mid-stream.** Drop rst_n between edges.
  - Outputs clear to 0 immediately.
  - After release, the first nomination uses ptr=0 (MODE 0) or the LFSR_SEED-derived start (MODE 1).
- **LFSR mode.** MODE 1, all four eligible, 20 cycles.
  - silver_idx matches the reference LFSR model from seed 0xA5 (start = low 2 bits) every cycle.
  - sel_cnt=20.
